// File: rtl/single_pkg.sv
// rtl/single_pkg.sv - shared types and constants for the single-precision arg-min slice
//
// Purpose: IEEE-754 single-precision field view, special-value constants,
//          the arg-min sequencer state encoding and a NaN classifier.
// Ports:   none (package).
// Config:  fp32_is_nan is used by single_argmin_seq only when
//          SINGLE_ARGMIN_NAN_SKIP_EN is defined.

package single_pkg;

  // Field view of a raw single-precision word; bit 31 is the sign.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } argmin_state_e;

  // Any NaN: all-ones exponent with a non-zero mantissa. Infinities return 0.
  function automatic logic fp32_is_nan(input fp32_t x);
    return (x.exp == FP32_EXP_MAX) && (x.man != 23'd0);
  endfunction

endpackage

// File: rtl/single_lt_cmp.sv
// rtl/single_lt_cmp.sv - combinational strict less-than over raw fp32 bits
//
// Purpose: total order on raw single-precision words, usable by any float
//          min/max/sort block. Sign decides first (so -0 < +0). With equal
//          signs the {exp,man} magnitude decides, reversed for negatives.
//          NaN and Inf get no special treatment; they sort by their bits.
// Ports:
//   a   in  32  left operand
//   b   in  32  right operand
//   lt  out 1   1 when a sorts strictly before b

module single_lt_cmp
  import single_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  fp32_t fa;
  fp32_t fb;
  logic  mag_lt;
  logic  mag_gt;

  always_comb begin
    fa     = a;
    fb     = b;
    mag_lt = {fa.exp, fa.man} < {fb.exp, fb.man};
    mag_gt = {fa.exp, fa.man} > {fb.exp, fb.man};
    lt     = 1'b0;
    if (fa.sign != fb.sign) begin
      // Only a negative a can be below a positive b.
      lt = fa.sign;
    end else if (!fa.sign) begin
      lt = mag_lt;
    end else begin
      // Both negative: the larger magnitude is the smaller value.
      lt = mag_gt;
    end
  end

endmodule

// File: rtl/single_argmin_seq.sv
// rtl/single_argmin_seq.sv - streaming arg-min sequencer for fp32 vectors
//
// Purpose: on start, consume len elements over a valid/ready stream and track
//          the running minimum and its 0-based index; pulse done one cycle
//          after the last element is accepted. One shared comparator, one
//          comparison per accepted element. Ties keep the first occurrence.
// Config:  SINGLE_ARGMIN_NAN_SKIP_EN - when defined, NaN elements are consumed
//          but never become the minimum; an all-NaN vector reports empty.
// Ports:
//   clk       in   1      clock, all state on posedge
//   rstn      in   1      asynchronous active-low reset
//   start     in   1      command strobe, sampled only in IDLE
//   len       in   IDX_W  element count, captured on start, clamped to MAX_LEN
//   in_valid  in   1      element present
//   in_ready  out  1      element accepted when in_valid && in_ready
//   in_data   in   32     fp32 element
//   busy      out  1      high in RUN and DONE
//   done      out  1      one-cycle result-valid pulse
//   empty     out  1      result came from a zero-length (or all-skipped) vector
//   min_val   out  32     minimum element, held until the next accepted start
//   min_idx   out  IDX_W  index of the minimum, held until the next accepted start

module single_argmin_seq
  import single_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int IDX_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [IDX_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             busy,
  output logic             done,
  output logic             empty,
  output logic [31:0]      min_val,
  output logic [IDX_W-1:0] min_idx
);

  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(MAX_LEN);

  argmin_state_e    state_q;
  argmin_state_e    state_d;

  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] cnt_q;
  logic             have_min_q;
  logic [31:0]      min_val_q;
  logic [IDX_W-1:0] min_idx_q;
  logic             empty_q;

  logic [IDX_W-1:0] len_clamped;
  logic             accept;
  logic             last_elem;
  logic             elem_lt;
  logic             elem_skip;
  logic             take;

  // The single comparator: incoming element against the running minimum.
  single_lt_cmp u_lt_cmp (
    .a  (in_data),
    .b  (min_val_q),
    .lt (elem_lt)
  );

`ifdef SINGLE_ARGMIN_NAN_SKIP_EN
  assign elem_skip = fp32_is_nan(fp32_t'(in_data));
`else
  assign elem_skip = 1'b0;
`endif

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign accept      = (state_q == RUN) && in_valid;
  // len_q is never zero in RUN, so len_q-1 does not wrap.
  assign last_elem   = (cnt_q == (len_q - 1'b1));
  // Strict less-than keeps the earlier index on ties.
  assign take        = !elem_skip && (!have_min_q || elem_lt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_elem) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q      <= '0;
      cnt_q      <= '0;
      have_min_q <= 1'b0;
      min_val_q  <= FP32_ZERO;
      min_idx_q  <= '0;
      empty_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q      <= len_clamped;
            cnt_q      <= '0;
            have_min_q <= 1'b0;
            min_val_q  <= FP32_ZERO;
            min_idx_q  <= '0;
            empty_q    <= (len == '0);
          end
        end
        RUN: begin
          if (accept) begin
            if (take) begin
              min_val_q  <= in_data;
              min_idx_q  <= cnt_q;
              have_min_q <= 1'b1;
            end
            cnt_q <= cnt_q + 1'b1;
            // Empty only when no element ever qualified (all skipped).
            if (last_elem) begin
              empty_q <= !(have_min_q || take);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign empty   = empty_q;
  assign min_val = min_val_q;
  assign min_idx = min_idx_q;

endmodule

// File: tb/tb_single_argmin_seq.sv
// tb/tb_single_argmin_seq.sv - scoreboard bench for single_argmin_seq

module tb_single_argmin_seq;

  localparam int MAX_LEN = 256;
  localparam int IDX_W   = 9;

  logic             clk      = 1'b0;
  logic             rstn     = 1'b1;
  logic             start    = 1'b0;
  logic [IDX_W-1:0] len      = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data  = '0;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             empty;
  logic [31:0]      min_val;
  logic [IDX_W-1:0] min_idx;

  typedef struct {
    logic [31:0]      val;
    logic [IDX_W-1:0] idx;
    logic             empty;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] vec[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  single_argmin_seq #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .empty    (empty),
    .min_val  (min_val),
    .min_idx  (min_idx)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference order: map each word to an unsigned key whose natural order is
  // the required float order, then compare keys.
  function automatic logic [31:0] okey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic bit ref_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] v, input int i, input bit e);
    exp_t r;
    r.val = v; r.idx = i[IDX_W-1:0]; r.empty = e;
    return r;
  endfunction

  function automatic exp_t model(input int n);
    exp_t r;
    bit   have;
    int   lim;
    have = 0;
    lim  = (n > MAX_LEN) ? MAX_LEN : n;
    r    = mk_exp(32'h0, 0, 1'b1);
    for (int i = 0; i < lim; i++) begin
`ifdef SINGLE_ARGMIN_NAN_SKIP_EN
      if (ref_nan(vec[i])) continue;
`endif
      if (!have || (okey(vec[i]) < okey(r.val))) begin
        r.val = vec[i]; r.idx = i[IDX_W-1:0]; r.empty = 1'b0; have = 1;
      end
    end
    return r;
  endfunction

  // Result monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      check_eq("in_ready_only_in_run", in_ready, busy && !done);
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("min_val", min_val, e.val);
          check_eq("min_idx", min_idx, e.idx);
          check_eq("empty", empty, e.empty);
        end
      end
    end
  end

  task automatic issue_start(input int n);
    @(posedge clk); #1;
    start = 1'b1; len = n[IDX_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds vec[0..nfeed-1]; returns 1ns after the last handshake edge.
  task automatic feed(input int nfeed, input bit gap, input bit poke);
    bit ok;
    int waited;
    for (int i = 0; i < nfeed; i++) begin
      ok = 0; waited = 0;
      in_valid = 1'b1; in_data = vec[i];
      if (poke && i == 2) begin start = 1'b1; len = 9'd2; end
      while (!ok && waited < 50) begin
        @(negedge clk);
        if (in_ready) ok = 1;
        @(posedge clk); #1;
        waited++;
      end
      start = 1'b0;
      if (!ok) begin
        check_eq("handshake_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (gap && i < nfeed - 1) begin
        in_valid = 1'b0; in_data = $urandom;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_cmd(input int n, input bit gap, input bit poke, input exp_t e);
    int nf;
    nf = (n > MAX_LEN) ? MAX_LEN : n;
    exp_q.push_back(e);
    issue_start(n);
    if (nf != 0) feed(nf, gap, poke);
    @(negedge clk);
    check_eq("done_latency", done, 1);
    check_eq("busy_in_done", busy, 1);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_after_done", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {in_ready, busy, done, empty, min_val, min_idx}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #2 rstn = 1'b0;
    #1 check_all_zero("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // Mixed signs, no bubbles.
    vec = {32'h4040_0000, 32'hBFC0_0000, 32'h4000_0000, 32'hBF00_0000};
    run_cmd(4, 1'b0, 1'b0, mk_exp(32'hBFC0_0000, 1, 1'b0));

    // -0 sorts below +0; valid toggles every other cycle.
    vec = {32'h0000_0000, 32'h8000_0000, 32'h40A0_0000};
    run_cmd(3, 1'b1, 1'b0, mk_exp(32'h8000_0000, 1, 1'b0));

    // Ties keep the first index; a start pulse mid-run is ignored.
    vec = {32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3F80_0000};
    run_cmd(5, 1'b0, 1'b1, mk_exp(32'h3F80_0000, 1, 1'b0));

    // Zero length: done the cycle after start, busy for exactly one cycle.
    run_cmd(0, 1'b0, 1'b0, mk_exp(32'h0, 0, 1'b1));

    // Reset after the 2nd of 6 elements: outputs clear at once, no done.
    vec = {32'hC000_0000, 32'hC100_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0};
    issue_start(6);
    feed(2, 1'b0, 1'b0);
    rstn = 1'b0;
    #1 check_all_zero("reset_mid_run");
    @(negedge clk) check_eq("no_done_in_reset", done, 0);
    rstn = 1'b1;
    @(negedge clk) check_eq("idle_after_reset", {busy, done}, 2'b00);
    vec = {32'h4000_0000, 32'hC000_0000};
    run_cmd(2, 1'b0, 1'b0, mk_exp(32'hC000_0000, 1, 1'b0));

`ifdef SINGLE_ARGMIN_NAN_SKIP_EN
    vec = {32'h7FC0_0000, 32'h40E0_0000, 32'h7FC0_0000};
    run_cmd(3, 1'b0, 1'b0, mk_exp(32'h40E0_0000, 1, 1'b0));
    vec = {32'h7FC0_0000, 32'hFFC0_0000};
    run_cmd(2, 1'b0, 1'b0, mk_exp(32'h0, 0, 1'b1));
`else
    vec = {32'hFFC0_0000, 32'h3F80_0000};
    run_cmd(2, 1'b0, 1'b0, mk_exp(32'hFFC0_0000, 0, 1'b0));
`endif

    // Random vector with bubbles, expectation from the reference order.
    vec.delete();
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) vec.push_back($urandom);
      else vec.push_back(($urandom_range(0, 1) == 1) ? 32'hBF80_0000 : 32'h8000_0000);
    end
    run_cmd(20, 1'b1, 1'b0, model(20));

    // Length above MAX_LEN is clamped: exactly MAX_LEN elements consumed.
    vec.delete();
    for (int i = 0; i < MAX_LEN; i++) vec.push_back($urandom);
    run_cmd(300, 1'b0, 1'b0, model(300));

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/single_argmin_seq.md
Name: single_argmin_seq

Overview:
- Streaming arg-min sequencer for IEEE-754 single-precision vectors.
- Accepts a start command with a vector length, consumes that many elements over a valid/ready stream, and keeps a running minimum plus its index.
- Reports the minimum value and index with a one-cycle done pulse.
- Sits between a sample buffer/DMA reader and downstream selection logic; owns the single shared comparator and schedules one comparison per accepted element.

Parameters:
- MAX_LEN, 256, largest vector length accepted; len values above MAX_LEN are clamped to MAX_LEN.
- IDX_W, $clog2(MAX_LEN+1), width of len and index fields.

Ports:
- clk  input  1  clock; all state on posedge.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  command strobe; sampled only in IDLE.
- len  input  IDX_W  element count for this command, captured on start.
- in_valid  input  1  element present.
- in_ready  output  1  element accepted when in_valid && in_ready.
- in_data  input  32  single-precision element.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- empty  output  1  result came from a zero-length command (or all elements skipped, see optional feature); valid with done, held after.
- min_val  output  32  minimum element; held until the next accepted start.
- min_idx  output  IDX_W  0-based index of the minimum; held until the next accepted start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=0, busy=0, done=0, empty=0, min_val=0, min_idx=0; counters=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=0.
  - On start with len==0: go to DONE with empty=1, min_val=0, min_idx=0.
  - On start with len>0: capture the clamped length, cnt=0, have_min=0, go to RUN.
- RUN: in_ready=1.
  - Each handshake compares in_data against min_val.
  - If !have_min or in_data < min_val: min_val<=in_data, min_idx<=cnt, have_min<=1.
  - Then cnt<=cnt+1.
  - The handshake with cnt==len-1 moves to DONE in the same cycle.
- DONE: done=1 for exactly one cycle, in_ready=0, then go to IDLE. Latency: done asserts on the cycle after the last element handshake.
- Comparison (strict less-than) uses a sign-magnitude total order on raw bits:
  - Sign differs: the negative operand is smaller, so -0 < +0.
  - Both positive: compare exponent, then mantissa; larger magnitude is larger.
  - Both negative: larger magnitude is smaller.
  - NaN/Inf are ordered by their bits, with no special casing.
- Ties: the equal later element does not replace the current minimum, so the first occurrence's index wins.
- start while busy: ignored, with no effect on the current run.
- in_valid low in RUN: stall with no state change; bubbles are unbounded.
- in_data outside RUN: ignored.
- Reset mid-RUN: immediate return to reset values; no done pulse.
- min_val/min_idx are updated live during RUN; consumers sample them only with done.

Optional Feature:
- Macro: SINGLE_ARGMIN_NAN_SKIP_EN.
- Defined:
  - Elements with exponent==8'hFF and mantissa!=0 are consumed (handshake and cnt increment) but never become the minimum.
  - If every element is NaN, empty=1 at done and min_val=0, min_idx=0.
- Undefined: NaNs participate under the raw-bit order above.

Decomposition:
- Package single_pkg:
  - typedef fp32_t (packed struct sign/exp[7:0]/man[22:0]).
  - constants FP32_EXP_MAX=8'hFF and FP32_ZERO.
  - enum argmin_state_e {IDLE, RUN, DONE}.
- Sub-module single_lt_cmp: purely combinational, inputs a and b (32 bits), output lt, implementing the total order above.
  - Instantiated once.
  - Reusable by other float min/max/sort blocks.

Test Plan:
- start, len=4, data {3.0, -1.5, 2.0, -0.5} with no bubbles -> done 1 cycle after the 4th handshake; min_val=32'hBFC00000, min_idx=1, empty=0.
- len=3, data {+0.0 (32'h00000000), -0.0 (32'h80000000), 5.0}, valid toggled every other cycle -> min_val=32'h80000000, min_idx=1; in_ready high throughout RUN.
- len=5 with a tie: {2.0, 1.0, 1.0, 4.0, 1.0} -> min_idx=1 (first occurrence); second start pulse during RUN has no effect.
- len=0 -> done on the cycle after start, empty=1, min_val=0, min_idx=0; busy high for exactly 1 cycle.
- rstn low after the 2nd of 6 elements -> all outputs 0 immediately, no done pulse; a fresh len=2 run afterwards gives the correct result.
- With SINGLE_ARGMIN_NAN_SKIP_EN, len=3 {NaN 32'h7FC00000, 7.0, NaN} -> min_val=7.0 (32'h40E00000), min_idx=1. An all-NaN len=2 run -> empty=1. Without the macro, {32'hFFC00000, 1.0} -> min_idx=0.
